// File: rtl/vga_pkg.sv
// Shared constants, control codes and state type for the text-mode display path.
// The character buffer and the text writer both size their ports from these widths.
package vga_pkg;

    localparam int TXT_COLS = 80;
    localparam int TXT_ROWS = 30;
    localparam int COL_W    = 7;
    localparam int ROW_W    = 5;
    localparam int CHAR_W   = 7;

    localparam logic [CHAR_W-1:0] ASCII_BS = 7'h08;
    localparam logic [CHAR_W-1:0] ASCII_LF = 7'h0A;
    localparam logic [CHAR_W-1:0] ASCII_FF = 7'h0C;
    localparam logic [CHAR_W-1:0] ASCII_CR = 7'h0D;
    localparam logic [CHAR_W-1:0] ASCII_SP = 7'h20;

    typedef enum logic [1:0] {
        TW_IDLE,
        TW_CLR_LINE,
        TW_CLR_SCREEN
    } tw_state_e;

    function automatic logic is_printable(input logic [CHAR_W-1:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/clear_seq.sv
// Address sweeper for clearing: either one row (row mode) or the whole screen,
// row-major. last_o flags the final address so the owner can stop on that write.
module clear_seq
    import vga_pkg::*;
#(
    parameter int COLS = TXT_COLS,
    parameter int ROWS = TXT_ROWS
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             row_mode_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic             advance_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_mode_q, row_mode_d;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_mode_d = row_mode_q;
        if (start_i) begin
            col_d      = '0;
            row_d      = row_mode_i ? row_i : '0;
            row_mode_d = row_mode_i;
        end else if (advance_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q      <= '0;
            row_q      <= '0;
            row_mode_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_mode_q <= row_mode_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == COL_LAST) && (row_mode_q || (row_q == ROW_LAST));

endmodule

// File: rtl/text_writer.sv
// Turns a valid/ready stream of ASCII codes into character-buffer writes at a
// hardware cursor, with wrap, control codes and line/screen clears.
module text_writer
    import vga_pkg::*;
#(
    parameter int COLS = TXT_COLS,
    parameter int ROWS = TXT_ROWS
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              char_valid_i,
    input  logic [CHAR_W-1:0] char_i,
    output logic              char_ready_o,
    output logic              wr_en_o,
    output logic [COL_W-1:0]  col_w_o,
    output logic [ROW_W-1:0]  row_w_o,
    output logic [CHAR_W-1:0] din_o,
    output logic [COL_W-1:0]  cur_col_o,
    output logic [ROW_W-1:0]  cur_row_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    tw_state_e         state_q, state_d;
    logic [COL_W-1:0]  cur_col_q, cur_col_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic              wr_en_q, wr_en_d;
    logic [COL_W-1:0]  col_w_q, col_w_d;
    logic [ROW_W-1:0]  row_w_q, row_w_d;
    logic [CHAR_W-1:0] din_q, din_d;

    logic [ROW_W-1:0]  row_next;
    logic              seq_start;
    logic              seq_row_mode;
    logic              seq_advance;
    logic [COL_W-1:0]  seq_col;
    logic [ROW_W-1:0]  seq_row;
    logic              seq_last;

    assign row_next    = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + ROW_W'(1);
    assign seq_advance = (state_q != TW_IDLE);

    clear_seq #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_clear_seq (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (seq_start),
        .row_mode_i (seq_row_mode),
        .row_i      (row_next),
        .advance_i  (seq_advance),
        .col_o      (seq_col),
        .row_o      (seq_row),
        .last_o     (seq_last)
    );

    // The cursor moves at the acceptance edge; a clear then runs on its own counter.
    always_comb begin
        state_d      = state_q;
        cur_col_d    = cur_col_q;
        cur_row_d    = cur_row_q;
        wr_en_d      = 1'b0;
        col_w_d      = col_w_q;
        row_w_d      = row_w_q;
        din_d        = din_q;
        seq_start    = 1'b0;
        seq_row_mode = 1'b1;

        case (state_q)
            TW_IDLE: begin
                if (char_valid_i) begin
                    if (is_printable(char_i)) begin
                        wr_en_d = 1'b1;
                        col_w_d = cur_col_q;
                        row_w_d = cur_row_q;
                        din_d   = char_i;
                        if (cur_col_q == COL_LAST) begin
                            cur_col_d = '0;
                            cur_row_d = row_next;
                            state_d   = TW_CLR_LINE;
                            seq_start = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + COL_W'(1);
                        end
                    end else begin
                        case (char_i)
                            ASCII_LF: begin
                                cur_col_d = '0;
                                cur_row_d = row_next;
                                state_d   = TW_CLR_LINE;
                                seq_start = 1'b1;
                            end
                            ASCII_CR: cur_col_d = '0;
                            ASCII_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = cur_col_q - COL_W'(1);
                                    wr_en_d   = 1'b1;
                                    col_w_d   = cur_col_q - COL_W'(1);
                                    row_w_d   = cur_row_q;
                                    din_d     = ASCII_SP;
                                end
                            end
                            ASCII_FF: begin
                                cur_col_d    = '0;
                                cur_row_d    = '0;
                                state_d      = TW_CLR_SCREEN;
                                seq_start    = 1'b1;
                                seq_row_mode = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            TW_CLR_LINE, TW_CLR_SCREEN: begin
                wr_en_d = 1'b1;
                col_w_d = seq_col;
                row_w_d = seq_row;
                din_d   = ASCII_SP;
                if (seq_last) begin
                    state_d = TW_IDLE;
                end
            end
            default: state_d = TW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= TW_IDLE;
            cur_col_q <= '0;
            cur_row_q <= '0;
            wr_en_q   <= 1'b0;
            col_w_q   <= '0;
            row_w_q   <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            wr_en_q   <= wr_en_d;
            col_w_q   <= col_w_d;
            row_w_q   <= row_w_d;
            din_q     <= din_d;
        end
    end

    assign char_ready_o = (state_q == TW_IDLE);
    assign wr_en_o      = wr_en_q;
    assign col_w_o      = col_w_q;
    assign row_w_o      = row_w_q;
    assign din_o        = din_q;
    assign cur_col_o    = cur_col_q;
    assign cur_row_o    = cur_row_q;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: stimulus pushes expected buffer writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_text_writer;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       char_valid_i = 1'b0;
    logic [6:0] char_i = 7'h00;
    logic       char_ready_o;
    logic       wr_en_o;
    logic [6:0] col_w_o;
    logic [4:0] row_w_o;
    logic [6:0] din_o;
    logic [6:0] cur_col_o;
    logic [4:0] cur_row_o;

    int assertions = 0;
    int failures   = 0;
    int wr_count   = 0;
    logic [18:0] sb_q[$];

    text_writer dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .char_valid_i (char_valid_i),
        .char_i       (char_i),
        .char_ready_o (char_ready_o),
        .wr_en_o      (wr_en_o),
        .col_w_o      (col_w_o),
        .row_w_o      (row_w_o),
        .din_o        (din_o),
        .cur_col_o    (cur_col_o),
        .cur_row_o    (cur_row_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rstn_i && wr_en_o) begin
            logic [18:0] got;
            got = {col_w_o, row_w_o, din_o};
            wr_count++;
            assertions++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL write_unexpected: got col=%0d row=%0d din=%02h, required no write",
                         col_w_o, row_w_o, din_o);
            end else begin
                logic [18:0] exp;
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL write: got col=%0d row=%0d din=%02h, required col=%0d row=%0d din=%02h",
                             col_w_o, row_w_o, din_o, exp[18:12], exp[11:7], exp[6:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic pushWrite(input int col, input int row, input int ch);
        sb_q.push_back({7'(col), 5'(row), 7'(ch)});
    endtask

    task automatic pushClearRow(input int row);
        for (int c = 0; c < 80; c++) pushWrite(c, row, 8'h20);
    endtask

    // Wait for ready (bounded), present the code for exactly one accepting edge.
    task automatic applyStimulus(input logic [6:0] ch);
        int n = 0;
        while (!char_ready_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 5000) checkOutput("ready_timeout", 0, 1);
        char_i       = ch;
        char_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        char_valid_i = 1'b0;
    endtask

    // Counts negedges with ready low, starting just after an acceptance.
    task automatic countBusy(output int n);
        n = 0;
        @(negedge clk_i);
        while (!char_ready_o && n < 5000) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic sendLf(input int new_row);
        pushClearRow(new_row);
        applyStimulus(7'h0A);
    endtask

    task automatic sendPrintables(input int count, input int row);
        for (int i = 0; i < count; i++) begin
            pushWrite(i, row, 8'h30 + (i % 10));
            applyStimulus(7'(8'h30 + (i % 10)));
        end
    endtask

    task automatic drain();
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("queue_drained", sb_q.size(), 0);
    endtask

    initial begin
        int busy;
        int base;
        int n;

        // Reset values
        repeat (2) @(negedge clk_i);
        checkOutput("rst_wr_en", wr_en_o, 0);
        checkOutput("rst_col_w", col_w_o, 0);
        checkOutput("rst_row_w", row_w_o, 0);
        checkOutput("rst_din", din_o, 0);
        checkOutput("rst_cur_col", cur_col_o, 0);
        checkOutput("rst_cur_row", cur_row_o, 0);
        checkOutput("rst_ready", char_ready_o, 1);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // 'A','B' back to back
        pushWrite(0, 0, 8'h41);
        pushWrite(1, 0, 8'h42);
        applyStimulus(7'h41);
        checkOutput("ab_ready_mid", char_ready_o, 1);
        applyStimulus(7'h42);
        checkOutput("ab_ready_after", char_ready_o, 1);
        checkOutput("ab_cur_col", cur_col_o, 2);
        checkOutput("ab_cur_row", cur_row_o, 0);
        drain();

        // Move to (79,3) then wrap with 'Z'
        sendLf(1);
        sendLf(2);
        sendLf(3);
        sendPrintables(79, 3);
        checkOutput("pre_z_col", cur_col_o, 79);
        pushWrite(79, 3, 8'h5A);
        pushClearRow(4);
        applyStimulus(7'h5A);
        checkOutput("z_cur_col", cur_col_o, 0);
        checkOutput("z_cur_row", cur_row_o, 4);
        countBusy(busy);
        checkOutput("z_ready_low_cycles", busy, 80);
        drain();

        // Ignored control code: accepted without stall or write
        applyStimulus(7'h01);
        checkOutput("ign_ready", char_ready_o, 1);
        checkOutput("ign_cur_col", cur_col_o, 0);

        // Move to (33,17) then FF
        for (int r = 5; r <= 17; r++) sendLf(r);
        sendPrintables(33, 17);
        drain();
        for (int r = 0; r < 30; r++) pushClearRow(r);
        applyStimulus(7'h0C);
        checkOutput("ff_cur_col", cur_col_o, 0);
        checkOutput("ff_cur_row", cur_row_o, 0);
        countBusy(busy);
        checkOutput("ff_ready_low_cycles", busy, 2400);
        drain();

        // BS / CR / BS at row 2
        sendLf(1);
        sendLf(2);
        sendPrintables(5, 2);
        drain();
        pushWrite(4, 2, 8'h20);
        applyStimulus(7'h08);
        checkOutput("bs_cur_col", cur_col_o, 4);
        checkOutput("bs_cur_row", cur_row_o, 2);
        drain();
        base = wr_count;
        applyStimulus(7'h0D);
        checkOutput("cr_cur_col", cur_col_o, 0);
        checkOutput("cr_cur_row", cur_row_o, 2);
        applyStimulus(7'h08);
        checkOutput("bs0_cur_col", cur_col_o, 0);
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("cr_bs0_no_write", wr_count - base, 0);

        // LF from (10,29) wraps to row 0
        for (int r = 3; r <= 29; r++) sendLf(r);
        sendPrintables(10, 29);
        drain();
        sendLf(0);
        checkOutput("lf_wrap_cur_col", cur_col_o, 0);
        checkOutput("lf_wrap_cur_row", cur_row_o, 0);
        countBusy(busy);
        checkOutput("lf_ready_low_cycles", busy, 80);
        drain();

        // Reset in the middle of a screen clear
        applyStimulus(7'h31);
        sb_q.push_back({7'd0, 5'd0, 7'h31});
        drain();
        for (int r = 0; r < 30; r++) pushClearRow(r);
        base = wr_count;
        applyStimulus(7'h0C);
        n = 0;
        while ((wr_count - base) < 500 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("mid_clear_reached", (wr_count - base) >= 500 ? 1 : 0, 1);
        #2;
        rstn_i = 1'b0;
        #1;
        checkOutput("rst_async_wr_en", wr_en_o, 0);
        checkOutput("rst_async_cur_col", cur_col_o, 0);
        checkOutput("rst_async_cur_row", cur_row_o, 0);
        sb_q.delete();
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        checkOutput("rst_release_ready", char_ready_o, 1);
        base = wr_count;
        repeat (100) @(negedge clk_i);
        #1;
        checkOutput("rst_no_resume", wr_count - base, 0);
        checkOutput("rst_ready_stays", char_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got timeout, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
